generic_mux: RTL and testbench

- Parameterised 2^N-to-1 multiplexer over K-bit data blocks.
- Primary output Y is purely combinational: zero latency, as used by datapath select logic.
- A registered copy Y_r provides a timing-friendly 1-cycle-delayed version for downstream pipelines.
- Single clock domain; synchronous active-high reset affects only the registered path.

---
 rtl/generic_mux.sv | 91 +++++++++
 tb/tb_generic_mux.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/generic_mux.sv
// -----------------------------------------------------------------------------
// generic_mux
//
// Parameterised 2^N-to-1 multiplexer over K-bit data blocks.
// Y is a purely combinational selection (zero latency) for datapath select
// logic. Y_r is a one-cycle registered copy for downstream pipelines.
//
// Parameters:
//   N  select width; the mux has 2^N input blocks (N >= 1)
//   K  width of each data block and of the outputs (K >= 1)
//
// Ports:
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous active-high reset (registered path only)
//   D        in   (2^N)*K    packed blocks, block i at D[i*K +: K], block 0 in LSBs
//   S        in   N          unsigned select index
//   Y        out  K          combinational selected block, D[S*K +: K]
//   Y_r      out  K          Y registered, one-cycle latency, cleared by rst
//
// Optional feature, enabled by defining GENERIC_MUX_PARITY_EN:
//   Y_par    out  1          XOR reduction of Y (combinational)
//   Y_r_par  out  1          XOR reduction of Y registered on the same edge as
//                            Y_r, cleared by rst
// With the macro undefined, the port list is exactly clk, rst, D, S, Y, Y_r.
// -----------------------------------------------------------------------------
module generic_mux #(
    parameter int N = 3,
    parameter int K = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [(2**N)*K-1:0]  D,
    input  logic [N-1:0]         S,
    output logic [K-1:0]         Y,
    output logic [K-1:0]         Y_r
`ifdef GENERIC_MUX_PARITY_EN
    ,
    output logic                 Y_par,
    output logic                 Y_r_par
`endif
);

    localparam int NBLK = 2**N;

    // Unpack the flat bus into an array of blocks. An N-bit select indexes
    // exactly NBLK entries, so there is no out-of-range case to handle.
    logic [K-1:0] blk [NBLK];

    for (genvar i = 0; i < NBLK; i++) begin : g_unpack
        assign blk[i] = D[i*K +: K];
    end

    assign Y = blk[S];

    // Registered copy of the selected block.
    logic [K-1:0] y_r_d;
    logic [K-1:0] y_r_q;

    assign y_r_d = Y;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_r_q <= '0;
        end else begin
            y_r_q <= y_r_d;
        end
    end

    assign Y_r = y_r_q;

`ifdef GENERIC_MUX_PARITY_EN
    // Parity is taken from the live Y so the registered parity lines up with
    // Y_r on the same edge rather than being recomputed from Y_r.
    logic y_r_par_d;
    logic y_r_par_q;

    assign Y_par     = ^Y;
    assign y_r_par_d = ^Y;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_r_par_q <= 1'b0;
        end else begin
            y_r_par_q <= y_r_par_d;
        end
    end

    assign Y_r_par = y_r_par_q;
`endif

endmodule

// File: tb/tb_generic_mux.sv
// -----------------------------------------------------------------------------
// tb_generic_mux
//
// Directed bench for generic_mux. Two instances: N=3/K=8 (main) and N=2/K=1
// (narrow). Inputs change just after the falling edge; outputs are sampled
// either after a short settle delay (combinational path) or on the falling
// edge (registered path). Parity outputs are exercised when
// GENERIC_MUX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_generic_mux;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance: N=3, K=8
    logic [63:0] d_a;
    logic [2:0]  s_a;
    logic [7:0]  y_a;
    logic [7:0]  y_r_a;

    // Narrow instance: N=2, K=1
    logic [3:0]  d_b;
    logic [1:0]  s_b;
    logic [0:0]  y_b;
    logic [0:0]  y_r_b;

`ifdef GENERIC_MUX_PARITY_EN
    logic        y_par_a;
    logic        y_r_par_a;
    logic        y_par_b;
    logic        y_r_par_b;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    generic_mux #(.N(3), .K(8)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .D       (d_a),
        .S       (s_a),
        .Y       (y_a),
        .Y_r     (y_r_a)
`ifdef GENERIC_MUX_PARITY_EN
        ,
        .Y_par   (y_par_a),
        .Y_r_par (y_r_par_a)
`endif
    );

    generic_mux #(.N(2), .K(1)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .D       (d_b),
        .S       (s_b),
        .Y       (y_b),
        .Y_r     (y_r_b)
`ifdef GENERIC_MUX_PARITY_EN
        ,
        .Y_par   (y_par_b),
        .Y_r_par (y_r_par_b)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        // block i = i
        for (int i = 0; i < 8; i++) d_a[i*8 +: 8] = 8'(i);
        s_a = 3'd0;
        // block i = i[0]: blocks 0..3 = 0,1,0,1
        d_b = 4'b1010;
        s_b = 2'd0;

        // Combinational sweep, main instance: Y equals S
        for (int s = 0; s < 8; s++) begin
            s_a = 3'(s);
            #10;
            chk($sformatf("sweep_a_s%0d", s), y_a, 8'(s));
        end

        // Combinational sweep, narrow instance: 0,1,0,1
        s_b = 2'd0; #10; chk("sweep_b_s0", {7'd0, y_b}, 8'd0);
        s_b = 2'd1; #10; chk("sweep_b_s1", {7'd0, y_b}, 8'd1);
        s_b = 2'd2; #10; chk("sweep_b_s2", {7'd0, y_b}, 8'd0);
        s_b = 2'd3; #10; chk("sweep_b_s3", {7'd0, y_b}, 8'd1);

        // Data tracking with fixed select
        s_a = 3'd5;
        #1;  chk("hold_s5_initial", y_a, 8'h05);
        d_a[5*8 +: 8] = 8'hA5;
        #1;  chk("block5_follow", y_a, 8'hA5);
        d_a[4*8 +: 8] = 8'h3C;
        #1;  chk("block4_ignored", y_a, 8'hA5);

        // Restore blocks for the registered-path tests
        for (int i = 0; i < 8; i++) d_a[i*8 +: 8] = 8'(i);

        // Registered path: two reset edges
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_y_r_a", y_r_a, 8'h00);
        chk("reset_y_r_b", {7'd0, y_r_b}, 8'd0);

        // Release reset with S=6; Y_r must not change before the edge
        rst = 1'b0;
        s_a = 3'd6;
        s_b = 2'd1;
        #1;
        chk("pre_edge_y_r_a", y_r_a, 8'h00);
        chk("comb_y_a_s6", y_a, 8'h06);
        @(posedge clk);
        @(negedge clk);
        chk("one_edge_y_r_a", y_r_a, 8'h06);
        chk("one_edge_y_r_b", {7'd0, y_r_b}, 8'd1);

        // Reset mid-stream: Y_r clears, Y keeps tracking
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_y_r_a", y_r_a, 8'h00);
        chk("mid_rst_y_a", y_a, 8'h06);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_y_r_a", y_r_a, 8'h06);

        // New select is picked up on the following edge
        s_a = 3'd2;
        @(posedge clk);
        @(negedge clk);
        chk("reselect_y_r_a", y_r_a, 8'h02);

`ifdef GENERIC_MUX_PARITY_EN
        // 0x07 has three ones -> parity 1; 0x03 has two -> parity 0
        s_a = 3'd7;
        #1;
        chk("par_s7", {7'd0, y_par_a}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        chk("r_par_s7", {7'd0, y_r_par_a}, 8'd1);
        s_a = 3'd3;
        #1;
        chk("par_s3", {7'd0, y_par_a}, 8'd0);
        chk("r_par_s3_held", {7'd0, y_r_par_a}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        chk("r_par_s3", {7'd0, y_r_par_a}, 8'd0);
        s_a = 3'd7;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("r_par_rst", {7'd0, y_r_par_a}, 8'd0);
        chk("par_during_rst", {7'd0, y_par_a}, 8'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("r_par_release", {7'd0, y_r_par_a}, 8'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
